// File: rtl/mpu_reg_pkg.sv
// Shared definitions for the MPU bridge register bank: doorbell FSM states,
// STATUS/DOORBELL bit positions and the offsets of the control words.
package mpu_reg_pkg;

  typedef enum logic [1:0] {
    DB_IDLE    = 2'd0,
    DB_REQ     = 2'd1,
    DB_RELEASE = 2'd2
  } db_state_e;

  localparam int STAT_BUSY_BIT = 0;
  localparam int STAT_DROP_BIT = 1;
  localparam int DB_GO_BIT     = 0;
  localparam int DROP_CLR_BIT  = 1;

  // Control words sit directly after the data registers.
  function automatic int doorbell_ofs(input int num_regs);
    return num_regs;
  endfunction

  function automatic int status_ofs(input int num_regs);
    return num_regs + 1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level, async active-high reset.
module sync_2ff (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // NOTE: sequential state is always written with <= so every flop samples
  // the pre-edge value of its neighbours.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/mpu_reg_bank.sv
// APF bridge register bank: NUM_REGS data registers, a four-phase doorbell and
// a STATUS word. Define MPU_REG_BANK_READBACK_EN to make data registers readable.
module mpu_reg_bank
  import mpu_reg_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int          NUM_REGS  = 8
) (
  input  logic                     write_clk,
  input  logic                     reset,
  input  logic [31:0]              bridge_addr,
  input  logic                     bridge_wr,
  input  logic [31:0]              bridge_wr_data,
  input  logic                     bridge_rd,
  output logic [31:0]              bridge_rd_data,
  output logic [NUM_REGS*32-1:0]   reg_data_out,
  output logic [NUM_REGS-1:0]      reg_write_trigger,
  output logic                     doorbell_req,
  input  logic                     doorbell_ack,
  input  logic [31:0]              status_in
);

  localparam int          IW     = $clog2(NUM_REGS);
  localparam logic [29:0] DB_OFS = 30'(doorbell_ofs(NUM_REGS));
  localparam logic [29:0] ST_OFS = 30'(status_ofs(NUM_REGS));

  logic [31:0]   w_diff;
  logic [29:0]   w_ofs;
  logic [IW-1:0] w_idx;
  logic          w_aligned, w_is_reg, w_is_db, w_is_st;

  // Addresses below BASE_ADDR wrap to a huge offset and fall out of range.
  assign w_diff    = bridge_addr - BASE_ADDR;
  assign w_ofs     = w_diff[31:2];
  assign w_idx     = w_ofs[IW-1:0];
  assign w_aligned = (w_diff[1:0] == 2'b00);
  assign w_is_reg  = w_aligned && (w_ofs < 30'(NUM_REGS));
  assign w_is_db   = w_aligned && (w_ofs == DB_OFS);
  assign w_is_st   = w_aligned && (w_ofs == ST_OFS);

  logic [31:0]         r_regs [NUM_REGS];
  logic [NUM_REGS-1:0] r_trig;

  // NOTE: the register array is small and its contents are architecturally
  // visible, so it takes the async reset like any other flop.
  always_ff @(posedge write_clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
      r_trig <= '0;
    end else begin
      r_trig <= '0;
      if (bridge_wr && w_is_reg) begin
        r_regs[w_idx] <= bridge_wr_data;
        r_trig[w_idx] <= 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_pack
    assign reg_data_out[32*g +: 32] = r_regs[g];
  end
  assign reg_write_trigger = r_trig;

  logic w_ack_sync;

  sync_2ff u_ack_sync (
    .i_clk (write_clk),
    .i_rst (reset),
    .i_d   (doorbell_ack),
    .o_q   (w_ack_sync)
  );

  db_state_e r_state, w_state_nxt;
  logic      w_busy, w_db_go, w_db_drop, w_drop_clr;
  logic      r_busy_drop;

  // req and busy look one cycle ahead of the state register so they react
  // as soon as the synchronized ack changes.
  assign w_busy     = (r_state == DB_REQ) || ((r_state == DB_RELEASE) && w_ack_sync);
  assign w_db_go    = bridge_wr && w_is_db && bridge_wr_data[DB_GO_BIT] && !w_busy;
  assign w_db_drop  = bridge_wr && w_is_db && !w_db_go;
  assign w_drop_clr = bridge_wr && w_is_st && bridge_wr_data[DROP_CLR_BIT];

  always_ff @(posedge write_clk or posedge reset) begin
    if (reset) r_state <= DB_IDLE;
    else       r_state <= w_state_nxt;
  end

  // NOTE: defaults come first so every path assigns every output and no
  // latch is inferred.
  always_comb begin
    w_state_nxt  = r_state;
    doorbell_req = 1'b0;
    case (r_state)
      DB_IDLE:    ;
      DB_REQ: begin
        doorbell_req = !w_ack_sync;
        if (w_ack_sync) w_state_nxt = DB_RELEASE;
      end
      DB_RELEASE: if (!w_ack_sync) w_state_nxt = DB_IDLE;
      default:    w_state_nxt = DB_IDLE;
    endcase
    if (w_db_go) w_state_nxt = DB_REQ;
  end

  always_ff @(posedge write_clk or posedge reset) begin
    if (reset)           r_busy_drop <= 1'b0;
    else if (w_db_drop)  r_busy_drop <= 1'b1;
    else if (w_drop_clr) r_busy_drop <= 1'b0;
  end

  logic [31:0] w_status, w_rd_val;
  logic [31:0] r_rd_data;

  always_comb begin
    w_status                = status_in;
    w_status[STAT_BUSY_BIT] = w_busy;
    w_status[STAT_DROP_BIT] = r_busy_drop;
    w_rd_val                = '0;
    if (w_is_st) w_rd_val = w_status;
`ifdef MPU_REG_BANK_READBACK_EN
    else if (w_is_reg) w_rd_val = r_regs[w_idx];
`endif
  end

  always_ff @(posedge write_clk or posedge reset) begin
    if (reset)          r_rd_data <= '0;
    else if (bridge_rd) r_rd_data <= w_rd_val;
  end

  assign bridge_rd_data = r_rd_data;

endmodule

// File: doc/mpu_reg_bank.md
MPU_REG_BANK -- requirements
Module: mpu_reg_bank

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h8000_0000, meaning the byte address of register 0 on the bridge.
REQ-002 SHALL have parameter NUM_REGS, default 8, meaning the number of 32-bit data registers (range 2..16).
REQ-003 SHALL have port write_clk, input, 1 bit: the single clock (APF bridge clock); all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port bridge_addr, input, 32 bits: bridge byte address.
REQ-006 SHALL have port bridge_wr, input, 1 bit: single-cycle write strobe.
REQ-007 SHALL have port bridge_wr_data, input, 32 bits: write data.
REQ-008 SHALL have port bridge_rd, input, 1 bit: single-cycle read strobe.
REQ-009 SHALL have port bridge_rd_data, output, 32 bits: read data.
REQ-010 SHALL have port reg_data_out, output, NUM_REGS*32 bits: packed register contents, reg n at bits [32n+31:32n].
REQ-011 SHALL have port reg_write_trigger, output, NUM_REGS bits: one-cycle pulse per register, aligned with the new reg_data_out value.
REQ-012 SHALL have port doorbell_req, output, 1 bit: four-phase request to the system-clock domain.
REQ-013 SHALL have port doorbell_ack, input, 1 bit: asynchronous acknowledge from the system-clock domain.
REQ-014 SHALL have port status_in, input, 32 bits: quasi-static status word, read-only.

Function
REQ-015 SHALL decode word offset = (bridge_addr - BASE_ADDR) >> 2 and ignore accesses with offset >= NUM_REGS+2 or bridge_addr[1:0] != 0.
REQ-016 SHALL, on bridge_wr at offset n < NUM_REGS, load reg n on that edge and assert reg_write_trigger[n] for exactly the following cycle.
REQ-017 SHALL treat offset NUM_REGS as DOORBELL: a write with bit0=1 while FSM is IDLE moves the FSM to REQ; otherwise the write is dropped and sticky bit BUSY_DROP is set.
REQ-018 SHALL treat offset NUM_REGS+1 as STATUS: read returns {status_in[31:2], BUSY_DROP, fsm_busy}; a write with bit1=1 clears BUSY_DROP.
REQ-019 SHALL implement FSM IDLE -> REQ (doorbell_req=1) -> on synchronized ack=1 -> RELEASE (doorbell_req=0) -> on synchronized ack=0 -> IDLE.
REQ-020 SHALL synchronize doorbell_ack through two flops before FSM use; fsm_busy=1 in REQ and RELEASE.
REQ-021 SHALL present bridge_rd_data one cycle after bridge_rd and hold it until the next read.
REQ-022 SHALL read 0 for unmapped or misaligned offsets.
REQ-023 SHALL give a write priority over a simultaneous BUSY_DROP set/clear only in the order: set wins over clear in the same cycle.
REQ-024 SHALL, when bridge_wr and bridge_rd coincide at the same offset, return the pre-write value.

Reset
REQ-025 SHALL, while reset=1, clear all registers, reg_write_trigger, bridge_rd_data, BUSY_DROP, synchronizer flops, set doorbell_req=0 and FSM=IDLE, regardless of write_clk.
REQ-026 SHALL abandon an in-flight doorbell on reset; the downstream side tolerates req falling mid-handshake.

Configuration
REQ-027 SHALL honour macro MPU_REG_BANK_READBACK_EN: when defined, data registers are readable at their offsets; when undefined, data-register reads return 0 and only STATUS is readable (saves the NUM_REGS:1 read mux).

Structure
REQ-028 SHALL take offset constants (DOORBELL_OFS, STATUS_OFS computation), FSM state enum and status bit positions from shared package mpu_reg_pkg.
REQ-029 SHALL instantiate sub-module sync_2ff (2-flop synchronizer, async active-high reset) for doorbell_ack.

Verification
REQ-030 SHALL cover: write 32'hDEAD_BEEF to BASE_ADDR+4 -> next cycle reg_data_out[63:32]=32'hDEAD_BEEF, reg_write_trigger=8'b0000_0010 for one cycle.
REQ-031 SHALL cover: read BASE_ADDR+4 with READBACK_EN -> bridge_rd_data=32'hDEAD_BEEF one cycle later; without macro -> 0.
REQ-032 SHALL cover: write 1 to DOORBELL, drive ack high after 5 cycles, low after 3 more -> req rises 1 cycle after write, falls 2 cycles after ack rise, FSM IDLE 2 cycles after ack fall.
REQ-033 SHALL cover: second DOORBELL write during REQ -> STATUS reads 32'h0000_0003 (with status_in=0); write 2 to STATUS -> reads 32'h0000_0001.
REQ-034 SHALL cover: write to BASE_ADDR+2 and to BASE_ADDR+4*(NUM_REGS+2) -> no trigger, no register change, read returns 0.
REQ-035 SHALL cover: assert reset while doorbell_req=1 -> doorbell_req=0 and all outputs 0 within the same cycle.
